// File: rtl/bpf_isa_pkg.sv
// Shared ISA definitions for the issue controller: opcode values,
// instruction field positions, the controller state encoding and an
// opcode classifier used by the EXEC state.
package bpf_isa_pkg;

    // Opcode values (instruction[15:12])
    localparam logic [3:0] OP_NOP     = 4'h0;
    localparam logic [3:0] OP_ALU_MIN = 4'h1;
    localparam logic [3:0] OP_MOV_IMM = 4'h8;
    localparam logic [3:0] OP_JMP     = 4'h9;
    localparam logic [3:0] OP_HALT    = 4'hF;

    // Instruction field positions
    localparam int OP_MSB  = 15;
    localparam int OP_LSB  = 12;
    localparam int DST_MSB = 11;
    localparam int DST_LSB = 10;
    localparam int SRC_MSB = 9;
    localparam int SRC_LSB = 8;
    localparam int IMM_MSB = 7;
    localparam int IMM_LSB = 0;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5
    } state_e;

    // What EXEC does with an opcode
    typedef enum logic [1:0] {
        CLS_SKIP  = 2'd0,   // nothing to write, fetch next
        CLS_WRITE = 2'd1,   // ALU / MOV_IMM, needs a write-back cycle
        CLS_JUMP  = 2'd2,   // JMP, only acted on when the jump feature is built in
        CLS_HALT  = 2'd3    // stop until reset
    } op_class_e;

    function automatic op_class_e classify(input logic [3:0] op);
        op_class_e cls;
        if (op == OP_HALT) begin
            cls = CLS_HALT;
        end else if (op == OP_JMP) begin
            cls = CLS_JUMP;
        end else if ((op >= OP_ALU_MIN) && (op <= OP_MOV_IMM)) begin
            cls = CLS_WRITE;
        end else begin
            cls = CLS_SKIP;
        end
        return cls;
    endfunction

endpackage

// File: rtl/issue_ctrl.sv
// Instruction fetch / issue sequencer: fetches from instruction memory,
// holds the instruction for decode, and pulses the register-file write
// enable for instructions that produce a result.
//
// Build option: define ISSUE_CTRL_JMP_EN to make opcode 9 (JMP) load the
// PC from the immediate field; without it, JMP is treated as a NOP.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | after reset, waiting for start
// FETCH  | imem_req high with imem_addr = PC until imem_ack
// DECODE | one cycle for the decode stage to see the new instruction
// EXEC   | classify opcode: write -> WB, halt -> HALT, otherwise FETCH
// WB     | rf_we high for this single cycle, then FETCH
// HALT   | stopped; only reset leaves this state
module issue_ctrl
    import bpf_isa_pkg::*;
#(
    parameter int INSN_LEN = 16,
    parameter int PC_W     = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    output logic                imem_req,
    output logic [PC_W-1:0]     imem_addr,
    input  logic                imem_ack,
    input  logic [INSN_LEN-1:0] imem_data,
    output logic [INSN_LEN-1:0] instruction,
    output logic                rf_we,
    output logic                busy,
    output logic                halted
);

    state_e              state_q, state_d;
    logic [PC_W-1:0]     pc_q, pc_d;
    logic [INSN_LEN-1:0] insn_q, insn_d;
    logic                imem_req_q;
    logic                rf_we_q;
    logic                busy_q;
    logic                halted_q;
    op_class_e           op_class;

    assign op_class = classify(insn_q[OP_MSB:OP_LSB]);

    // Next-state, PC and instruction-register selection
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        insn_d  = insn_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_FETCH;
                    pc_d    = '0;
                end
            end
            ST_FETCH: begin
                if (imem_ack) begin
                    insn_d  = imem_data;
                    pc_d    = pc_q + 1'b1;
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                case (op_class)
                    CLS_WRITE: state_d = ST_WB;
                    CLS_HALT:  state_d = ST_HALT;
                    CLS_JUMP: begin
                        state_d = ST_FETCH;
`ifdef ISSUE_CTRL_JMP_EN
                        pc_d    = PC_W'(insn_q[IMM_MSB:IMM_LSB]);
`endif
                    end
                    default:   state_d = ST_FETCH;
                endcase
            end
            ST_WB: begin
                state_d = ST_FETCH;
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, PC, instruction register and registered outputs; outputs are
    // decoded from the next state so they line up with the state they belong to
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            pc_q       <= '0;
            insn_q     <= '0;
            imem_req_q <= 1'b0;
            rf_we_q    <= 1'b0;
            busy_q     <= 1'b0;
            halted_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            insn_q     <= insn_d;
            imem_req_q <= (state_d == ST_FETCH);
            rf_we_q    <= (state_d == ST_WB);
            busy_q     <= (state_d != ST_IDLE) && (state_d != ST_HALT);
            halted_q   <= (state_d == ST_HALT);
        end
    end

    assign imem_req    = imem_req_q;
    assign imem_addr   = pc_q;
    assign instruction = insn_q;
    assign rf_we       = rf_we_q;
    assign busy        = busy_q;
    assign halted      = halted_q;

endmodule

// File: tb/tb_issue_ctrl.sv
// Scoreboard bench for issue_ctrl: stimulus pushes expected fetch
// addresses and rf_we cycles; a monitor pops and compares them as the
// DUT completes fetches and write-backs.
module tb_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic        imem_ack;
    logic [15:0] imem_data;
    logic [15:0] instruction;
    logic        rf_we;
    logic        busy;
    logic        halted;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [15:0] mem [256];
    int          ack_delay = 0;
    bit          mem_off   = 1'b0;
    bit          man_ack   = 1'b0;
    logic [15:0] man_data  = 16'h0;

    int exp_addr_q [$];
    int exp_we_q   [$];

    issue_ctrl #(.INSN_LEN(16), .PC_W(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_data   (imem_data),
        .instruction (instruction),
        .rf_we       (rf_we),
        .busy        (busy),
        .halted      (halted)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic fill_mem(input logic [15:0] v);
        for (int i = 0; i < 256; i++) mem[i] = v;
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_halted(input int max_cyc, input string name);
        int n;
        n = 0;
        while (!halted && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        chk(name, halted, 1);
    endtask

    task automatic drained(input string name);
        chk({name, "_fetch_left"}, exp_addr_q.size(), 0);
        chk({name, "_we_left"}, exp_we_q.size(), 0);
        exp_addr_q.delete();
        exp_we_q.delete();
    endtask

    // Instruction memory responder with programmable ack latency
    initial begin
        int wc;
        wc = 0;
        imem_ack  = 1'b0;
        imem_data = 16'h0;
        forever begin
            @(posedge clk);
            #1;
            if (mem_off) begin
                imem_ack  = man_ack;
                imem_data = man_data;
                wc = 0;
            end else if (imem_req && !rst) begin
                if (wc >= ack_delay) begin
                    imem_ack  = 1'b1;
                    imem_data = mem[imem_addr];
                    wc = 0;
                end else begin
                    imem_ack = 1'b0;
                    wc++;
                end
            end else begin
                imem_ack = 1'b0;
                wc = 0;
            end
        end
    end

    // Monitor: completed fetches and write-enable pulses against the scoreboard
    initial begin
        int e;
        forever begin
            @(negedge clk);
            if (imem_req && imem_ack) begin
                if (exp_addr_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL fetch_unexpected actual=%0h required=none", imem_addr);
                end else begin
                    e = exp_addr_q.pop_front();
                    chk("fetch_addr", imem_addr, e);
                end
            end
            if (rf_we) begin
                if (exp_we_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rf_we_unexpected actual_cycle=%0d required=none", cyc);
                end else begin
                    e = exp_we_q.pop_front();
                    chk("rf_we_cycle", cyc, e);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int s;
        rst   = 1'b1;
        start = 1'b0;
        fill_mem(16'h0000);

        // Reset state
        @(negedge clk);
        chk("rst_req", imem_req, 0);
        chk("rst_addr", imem_addr, 0);
        chk("rst_insn", instruction, 0);
        chk("rst_rf_we", rf_we, 0);
        chk("rst_busy", busy, 0);
        chk("rst_halted", halted, 0);
        @(negedge clk);
        rst = 1'b0;

        // Zero-wait MOV_IMM, NOP, HALT; start held high while busy
        fill_mem(16'h0000);
        mem[0] = 16'h8123;
        mem[1] = 16'h0000;
        mem[2] = 16'hF000;
        ack_delay = 0;
        exp_addr_q.push_back(0);
        exp_addr_q.push_back(1);
        exp_addr_q.push_back(2);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        s = cyc;
        exp_we_q.push_back(s + 3);
        repeat (8) @(negedge clk);
        start = 1'b0;
        while (cyc < s + 9) @(negedge clk);
        chk("t1_halted_cycle10", halted, 0);
        chk("t1_busy_cycle10", busy, 1);
        @(negedge clk);
        chk("t1_halted_cycle11", halted, 1);
        chk("t1_busy_cycle11", busy, 0);
        chk("t1_pc_after_halt", imem_addr, 3);
        drained("t1");

        // start while halted is ignored
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("t1_halt_start_halted", halted, 1);
        chk("t1_halt_start_req", imem_req, 0);
        chk("t1_halt_start_pc", imem_addr, 3);

        // Ack delayed by 3 cycles on address 0
        do_reset();
        fill_mem(16'h0000);
        mem[0] = 16'h8AB7;
        mem[1] = 16'hF000;
        ack_delay = 3;
        exp_addr_q.push_back(0);
        exp_addr_q.push_back(1);
        start = 1'b1;
        @(posedge clk);
        #1;
        s = cyc;
        exp_we_q.push_back(s + 6);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            start = 1'b0;
            chk("t2_wait_req", imem_req, 1);
            chk("t2_wait_addr", imem_addr, 0);
            chk("t2_wait_insn", instruction, 0);
        end
        @(negedge clk);
        chk("t2_insn_captured", instruction, 16'h8AB7);
        chk("t2_req_dropped", imem_req, 0);
        wait_halted(40, "t2_halted");
        drained("t2");

        // PC wrap 0xFF -> 0x00 over a run of NOPs
        do_reset();
        fill_mem(16'h0000);
        ack_delay = 0;
        for (int i = 0; i < 256; i++) exp_addr_q.push_back(i);
        exp_addr_q.push_back(0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        mem[0] = 16'hF000;
        wait_halted(900, "t3_halted");
        chk("t3_pc_after_wrap", imem_addr, 1);
        drained("t3");

        // Reset during a fetch wait, late ack after release is ignored
        do_reset();
        mem_off  = 1'b1;
        man_ack  = 1'b0;
        man_data = 16'h8555;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("t4_req_waiting", imem_req, 1);
        rst = 1'b1;
        #1;
        chk("t4_rst_req", imem_req, 0);
        chk("t4_rst_busy", busy, 0);
        chk("t4_rst_addr", imem_addr, 0);
        @(negedge clk);
        rst = 1'b0;
        man_ack = 1'b1;
        @(negedge clk);
        man_ack = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("t4_busy", busy, 0);
            chk("t4_insn", instruction, 0);
            chk("t4_req", imem_req, 0);
        end
        mem_off = 1'b0;
        drained("t4");

        // JMP with immediate 0x10 at address 0
        do_reset();
        fill_mem(16'h0000);
        mem[0]  = 16'h9010;
        mem[1]  = 16'hF000;
        mem[16] = 16'hF000;
        ack_delay = 0;
        exp_addr_q.push_back(0);
`ifdef ISSUE_CTRL_JMP_EN
        exp_addr_q.push_back(16);
`else
        exp_addr_q.push_back(1);
`endif
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_halted(30, "t5_halted");
`ifdef ISSUE_CTRL_JMP_EN
        chk("t5_pc_after_jmp", imem_addr, 8'h11);
`else
        chk("t5_pc_after_jmp", imem_addr, 8'h02);
`endif
        drained("t5");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/issue_ctrl.md
ISSUE_CTRL -- requirements
Module: issue_ctrl

Interface
REQ-001 SHALL have parameter INSN_LEN, default 16, instruction width in bits.
REQ-002 SHALL have parameter PC_W, default 8, program counter width in bits.
REQ-003 SHALL have port clk, input, 1, single clock; all state on rising edge.
REQ-004 SHALL have port rst, input, 1, reset; asynchronous, active-high.
REQ-005 SHALL have port start, input, 1, pulse to leave IDLE and begin fetching at PC 0.
REQ-006 SHALL have port imem_req, output, 1, instruction fetch request.
REQ-007 SHALL have port imem_addr, output, PC_W, fetch address (current PC).
REQ-008 SHALL have port imem_ack, input, 1, fetch data valid this cycle.
REQ-009 SHALL have port imem_data, input, INSN_LEN, fetched instruction.
REQ-010 SHALL have port instruction, output, INSN_LEN, held instruction register driving the decode stage.
REQ-011 SHALL have port rf_we, output, 1, register-file write enable, one cycle wide.
REQ-012 SHALL have port busy, output, 1, high in any state other than IDLE and HALT.
REQ-013 SHALL have port halted, output, 1, high in HALT.

Function
REQ-014 SHALL implement states IDLE, FETCH, DECODE, EXEC, WB, HALT.
REQ-015 IDLE -> FETCH on start; start is ignored in every other state.
REQ-016 In FETCH, imem_req SHALL stay high with imem_addr = PC until imem_ack; req/addr stable while waiting.
REQ-017 On imem_ack, instruction <= imem_data; PC <= PC+1 modulo 2^PC_W (0xFF wraps to 0x00); next state DECODE.
REQ-018 DECODE SHALL last exactly one cycle, then EXEC.
REQ-019 In EXEC, opcode = instruction[15:12] is classified.
- 4'h0 (NOP) -> FETCH.
- 4'h1..4'h8 (ALU ops, MOV_IMM = 8) -> WB.
- 4'hF (HALT) -> HALT.
- other -> FETCH.
REQ-020 WB SHALL assert rf_we for exactly one cycle, then FETCH.
REQ-021 rf_we SHALL be low in every state other than WB.
REQ-022 Minimum latency SHALL be 4 cycles per write instruction and 3 per non-write instruction, with zero-wait ack.
REQ-023 imem_ack outside FETCH SHALL be ignored.
REQ-024 HALT SHALL be left only by reset.
REQ-025 instruction SHALL hold its value in all states except FETCH-with-ack.

Reset
REQ-026 rst high SHALL immediately force IDLE, PC 0, instruction 0, imem_req 0, imem_addr 0, rf_we 0, busy 0, halted 0.
REQ-027 Reset mid-fetch SHALL drop imem_req the same cycle; a late ack after reset release SHALL be ignored.

Configuration
REQ-028 Macro ISSUE_CTRL_JMP_EN SHALL control the jump feature.
- Defined: opcode 4'h9 (JMP) in EXEC SHALL load PC <= instruction[7:0] (zero-extended/truncated to PC_W) and go to FETCH, no rf_we.
- Undefined: 4'h9 SHALL behave as NOP.

Structure
REQ-029 Shared package bpf_isa_pkg SHALL hold:
- opcode constants (NOP, MOV_IMM=8, JMP=9, HALT=F);
- instruction field positions (op 15:12, dst 11:10, src 9:8, imm 7:0);
- the state enum.
REQ-030 issue_ctrl SHALL be a single module; PC register and FSM inline, no sub-module.

Verification
REQ-031 Zero-wait program at 0..2: MOV_IMM, NOP, HALT; start -> rf_we exactly once, at cycle 4 after start; halted by cycle 11.
REQ-032 Ack delayed 3 cycles on address 0 -> imem_req held high with imem_addr=0 for 4 cycles; instruction unchanged until ack.
REQ-033 PC at 0xFF, NOP fetched -> next imem_addr = 0x00.
REQ-034 rst asserted during FETCH wait, then ack 1 cycle after release -> state IDLE, instruction 0, no DECODE entered.
REQ-035 JMP imm=0x10 at address 0:
- With ISSUE_CTRL_JMP_EN: next imem_addr = 0x10.
- Without: next imem_addr = 0x01.
REQ-036 start pulsed while busy or halted -> no change of state or PC.
